// File: rtl/sm_step_tracker.sv
`default_nettype none
// ============================================================================
// Module   : sm_step_tracker
// Purpose  : Position tracker downstream of the stepper pulse generator.
//            Counts step pulses, keeps a signed wrapping position, compares
//            it against a loaded target and supervises the limit switches.
//            A one-cycle stop_req is issued to the generator's stop command
//            when the target is reached or a limit is violated.
// Ports    : clk, rst             clock, synchronous active-high reset
//            step_in, step_inv    raw step line and its polarity (s = xor)
//            dir                  1 = forward (+1), 0 = reverse (-1)
//            lim_fwd, lim_rev     asynchronous limit switches
//            zero                 clear position and step count
//            load_target, target  latch target / arm the compare
//            abort, clear_fault   disarm compare / leave HALT
//            position, step_cnt   current position, saturating step count
//            armed, limit_hit     state flags (ARMED, HALT)
//            at_target, stop_req  registered one-cycle pulses
// Revision : 1.0 - initial release
// ============================================================================
module sm_step_tracker #(
    parameter int POS_W = 32,
    parameter int CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    step_in,
    input  logic                    step_inv,
    input  logic                    dir,
    input  logic                    lim_fwd,
    input  logic                    lim_rev,
    input  logic                    zero,
    input  logic                    load_target,
    input  logic signed [POS_W-1:0] target,
    input  logic                    abort,
    input  logic                    clear_fault,
    output logic signed [POS_W-1:0] position,
    output logic        [CNT_W-1:0] step_cnt,
    output logic                    armed,
    output logic                    at_target,
    output logic                    stop_req,
    output logic                    limit_hit
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_armed = 2'd1;
    localparam logic [1:0] c_st_halt  = 2'd2;

    localparam logic signed [POS_W-1:0] c_pos_one = {{(POS_W-1){1'b0}}, 1'b1};
    localparam logic        [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic        [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    logic [1:0]              r_state;
    logic signed [POS_W-1:0] r_pos;
    logic [CNT_W-1:0]        r_cnt;
    logic signed [POS_W-1:0] r_tgt;
    logic                    r_at;
    logic                    r_stop;
    logic                    r_step_prev;
    logic                    r_fwd_m;
    logic                    r_fwd_s;
    logic                    r_rev_m;
    logic                    r_rev_s;

    logic                    w_s;
    logic                    w_edge;
    logic                    w_blocked;
    logic signed [POS_W-1:0] w_pos_step;
    logic [1:0]              w_state_nxt;
    logic signed [POS_W-1:0] w_pos_nxt;
    logic [CNT_W-1:0]        w_cnt_nxt;
    logic signed [POS_W-1:0] w_tgt_nxt;
    logic                    w_at_nxt;
    logic                    w_stop_nxt;

    // Previous-level register resets high so a line that is already high
    // when reset releases is not mistaken for a step.
    assign w_s        = step_in ^ step_inv;
    assign w_edge     = w_s & ~r_step_prev;
    // Blocking uses the synchronized limit levels only.
    assign w_blocked  = dir ? r_fwd_s : r_rev_s;
    assign w_pos_step = dir ? (r_pos + c_pos_one) : (r_pos - c_pos_one);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_pos       <= '0;
            r_cnt       <= '0;
            r_tgt       <= '0;
            r_at        <= 1'b0;
            r_stop      <= 1'b0;
            r_step_prev <= 1'b1;
            r_fwd_m     <= 1'b0;
            r_fwd_s     <= 1'b0;
            r_rev_m     <= 1'b0;
            r_rev_s     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pos       <= w_pos_nxt;
            r_cnt       <= w_cnt_nxt;
            r_tgt       <= w_tgt_nxt;
            r_at        <= w_at_nxt;
            r_stop      <= w_stop_nxt;
            r_step_prev <= w_s;
            r_fwd_m     <= lim_fwd;
            r_fwd_s     <= r_fwd_m;
            r_rev_m     <= lim_rev;
            r_rev_s     <= r_rev_m;
        end
    end

    // Events are mutually exclusive within a cycle; the if/else chain encodes
    // their priority: zero, clear_fault, blocked step, step, abort, load.
    always_comb begin
        w_state_nxt = r_state;
        w_pos_nxt   = r_pos;
        w_cnt_nxt   = r_cnt;
        w_tgt_nxt   = r_tgt;
        w_at_nxt    = 1'b0;
        w_stop_nxt  = 1'b0;

        if (zero) begin
            // A same-cycle step is discarded; state is kept.
            w_pos_nxt = '0;
            w_cnt_nxt = '0;
        end else if (r_state == c_st_halt) begin
            // Everything except clear_fault is ignored while halted.
            if (clear_fault) begin
                w_state_nxt = c_st_idle;
            end
        end else if (w_edge && w_blocked) begin
            w_stop_nxt  = 1'b1;
            w_state_nxt = c_st_halt;
        end else if (w_edge) begin
            w_pos_nxt = w_pos_step;
            if (r_cnt != c_cnt_max) begin
                w_cnt_nxt = r_cnt + c_cnt_one;
            end
            if ((r_state == c_st_armed) && (w_pos_step == r_tgt)) begin
                w_at_nxt    = 1'b1;
                w_stop_nxt  = 1'b1;
                w_state_nxt = c_st_idle;
            end
        end else if (abort && (r_state == c_st_armed)) begin
            w_state_nxt = c_st_idle;
        end else if (load_target) begin
            if ((r_state == c_st_idle) && (target == r_pos)) begin
                // Already there: report immediately without arming.
                w_at_nxt   = 1'b1;
                w_stop_nxt = 1'b1;
            end else begin
                w_tgt_nxt   = target;
                w_state_nxt = c_st_armed;
            end
        end
    end

    assign position  = r_pos;
    assign step_cnt  = r_cnt;
    assign armed     = (r_state == c_st_armed);
    assign limit_hit = (r_state == c_st_halt);
    assign at_target = r_at;
    assign stop_req  = r_stop;

endmodule
`default_nettype wire
